// File: rtl/match_encoder_pkg.sv
// match_encoder_pkg: state type and width helpers shared by match_encoder and lsb_encoder
package match_encoder_pkg;
   typedef enum logic {IDLE, EMIT} match_enc_state_t;
   function automatic int vec_w(input int n_bits);
      return 1 << n_bits;
   endfunction
   function automatic int cnt_w(input int n_bits);
      return $clog2(vec_w(n_bits)) + 1;
   endfunction
endpackage

// File: rtl/match_encoder_lsb_encoder.sv
// lsb_encoder: combinational lowest-set-bit index with any-set and single-set flags
module lsb_encoder
   import match_encoder_pkg::*;
#(
   parameter int N_BITS = 8
) (
   input  logic [vec_w(N_BITS)-1:0] vec_i,
   output logic [N_BITS-1:0]        idx_o,
   output logic                     any_o,
   output logic                     one_o
);
   localparam int W = vec_w(N_BITS);
   // Scan downward so the lowest set bit is the last to write idx_o.
   always_comb begin
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--)
         if (vec_i[i]) idx_o = i[N_BITS-1:0];
   end
   assign any_o = |vec_i;
   assign one_o = any_o && ((vec_i & (vec_i - W'(1))) == '0);
endmodule

// File: rtl/match_encoder.sv
// match_encoder: reports every set match line lowest first over valid/ready; MATCH_ENCODER_COUNT_EN adds count_o popcount
module match_encoder
   import match_encoder_pkg::*;
#(
   parameter int N_BITS = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [vec_w(N_BITS)-1:0] match_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [N_BITS-1:0]        index_o,
   output logic [N_BITS-1:0]        index_no,
   output logic                     last_o,
   output logic                     busy_o,
   output logic                     miss_o,
   output logic                     done_o
`ifdef MATCH_ENCODER_COUNT_EN
   ,output logic [cnt_w(N_BITS)-1:0] count_o
`endif
);
   localparam int W = vec_w(N_BITS);
   match_enc_state_t state_q, state_d;
   logic [W-1:0] pend_q, pend_d;
   logic miss_q, miss_d, done_q, done_d;
   logic [N_BITS-1:0] idx;
   logic pend_any, pend_one, accept;

   lsb_encoder #(.N_BITS(N_BITS)) u_lsb (
      .vec_i(pend_q),
      .idx_o(idx),
      .any_o(pend_any),
      .one_o(pend_one)
   );

   assign accept = (state_q == IDLE) && start_i;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      miss_d  = 1'b0;
      done_d  = 1'b0;
      if (accept) begin
         pend_d  = match_i;
         miss_d  = match_i == '0;
         done_d  = match_i == '0;
         state_d = (match_i == '0) ? IDLE : EMIT;
      end else if (valid_o && ready_i) begin
         // Clearing the lowest set bit retires exactly the index being presented.
         pend_d  = pend_q & (pend_q - W'(1));
         done_d  = pend_one;
         state_d = pend_one ? IDLE : EMIT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pend_q  <= '0;
         miss_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         miss_q  <= miss_d;
         done_q  <= done_d;
      end
   end

   assign busy_o   = state_q == EMIT;
   assign valid_o  = busy_o && pend_any;
   assign index_o  = idx;
   assign index_no = ~idx;
   assign last_o   = valid_o && pend_one;
   assign miss_o   = miss_q;
   assign done_o   = done_q;

`ifdef MATCH_ENCODER_COUNT_EN
   localparam int CW = cnt_w(N_BITS);
   logic [CW-1:0] count_q, count_d;
   always_comb begin
      count_d = count_q;
      if (accept) begin
         count_d = '0;
         for (int i = 0; i < W; i++) count_d = count_d + CW'(match_i[i]);
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end
   assign count_o = count_q;
`endif
endmodule

// File: doc/match_encoder.md
# match_encoder

Sequential match-line encoder: the inverse of the one-hot address decoder. It captures a vector of 2**N_BITS match lines and reports the binary index of every set line, lowest first, one per valid/ready handshake. It flags a miss when no line is set. It sits behind the match array and feeds addresses back in both true and active-low form, so the decoder's active-low address input can be driven directly.

## Interface
- N_BITS, 8, index width; the match vector is 2**N_BITS wide.

- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  capture request; honoured only in IDLE
- match_i  in  2**N_BITS  match lines, active-high, sampled on an accepted start_i
- valid_o  out  1  index_o/index_no hold a pending match
- ready_i  in  1  consumer accepts the current index
- index_o  out  N_BITS  lowest pending match index
- index_no  out  N_BITS  bitwise inverse of index_o
- last_o  out  1  the current index is the final pending match
- busy_o  out  1  state is EMIT
- miss_o  out  1  one-cycle pulse: the captured vector was all-zero
- done_o  out  1  one-cycle pulse: the capture has been fully reported
- count_o  out  N_BITS+1  popcount of the captured vector (only with MATCH_ENCODER_COUNT_EN)

## Operation
- States: IDLE, EMIT.
- Registered pending vector `pend`, 2**N_BITS bits.
- IDLE with start_i=1:
  - pend <= match_i.
  - If match_i == 0: stay in IDLE, pulse miss_o and done_o next cycle.
  - Otherwise: go to EMIT.
- EMIT:
  - valid_o=1.
  - index_o = position of the lowest set bit of pend.
  - last_o=1 when pend has exactly one set bit.
- Handshake in EMIT:
  - On valid_o && ready_i, clear that bit in pend.
  - If last_o was 1: go to IDLE and pulse done_o next cycle.
- While valid_o=1 and ready_i=0, index_o, index_no and last_o hold stable.
- start_i is ignored in EMIT; match_i changes after capture have no effect.
- Back-to-back operation: start_i is accepted in the same cycle that done_o pulses, because the state is already IDLE.
- index_no = ~index_o at all times.
- Reset (at any time, including mid-EMIT):
  - pend=0, state IDLE.
  - valid_o=0, index_o=0, index_no=all ones.
  - last_o=0, busy_o=0, miss_o=0, done_o=0, count_o=0.
  - Pending matches are discarded with no done_o.

## Timing
- start_i accepted at edge t: valid_o (or miss_o with done_o) is high from cycle t+1.
- Each handshake at edge k: the next index is presented at k+1 with no bubble, so throughput is 1 index per cycle with ready_i held high.
- A capture with M>0 matches and ready_i held high: valid_o high for M cycles, done_o in cycle t+M+1.
- index_o is combinational from registered pend through the priority encoder; all other outputs are registered or decoded from state.
- busy_o equals valid_o.

## Configuration
- MATCH_ENCODER_COUNT_EN defined:
  - count_o port present.
  - Loaded with the popcount of match_i on the accepted start_i, visible from t+1.
  - Held until the next capture; 0 on a miss.
- MATCH_ENCODER_COUNT_EN undefined:
  - count_o port and popcount logic absent.
  - All other behaviour is identical.

## Structure
- match_encoder_pkg:
  - state typedef `match_enc_state_t` {IDLE, EMIT}.
  - Helper function clog2-based width constants.
- Sub-module lsb_encoder, combinational, parameter N_BITS:
  - Inputs: vector.
  - Outputs: lowest-set index, any-set flag, single-set flag.
  - Instantiated once on pend.

## Test plan
- Reset mid-EMIT:
  - match_i=0x0000_0006, ready_i=0, assert rst_ni=0 one cycle -> all outputs at reset values.
  - No done_o; a new start is accepted afterwards.
- Single match:
  - match_i bit 5 only, start_i, ready_i=1 -> t+1 shows valid_o=1, index_o=5, index_no=8'hFA, last_o=1.
  - done_o at t+2; count_o=1.
- Multi match with ready_i=1:
  - bits {0,7,255} -> indices 0, 7, 255 on consecutive cycles.
  - last_o only with 255; done_o the cycle after.
- Backpressure:
  - bits {3,4}, ready_i=0 for 4 cycles -> index_o holds at 3 and start_i is ignored.
  - On ready_i=1, 3 then 4 are emitted.
- Miss:
  - match_i=0, start_i -> miss_o=1 and done_o=1 at t+1, valid_o never asserts, count_o=0.
- Back-to-back:
  - start_i held high across captures {2} then {9} -> index 2, done_o together with the second capture, then index 9.
